// File: rtl/mem_bus_master.sv
// LC-3 memory bus initiator: turns a one-cycle load/store request into a bus
// transaction with a minimum MIOEN hold time and a timeout.
module mem_bus_master #(
    parameter int unsigned MIN_WAIT = 1,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] rdata,
    output logic        MIOEN,
    output logic        RW,
    output logic [15:0] memAddr,
    output logic [15:0] memWData,
    input  logic [15:0] memRData,
    input  logic        R
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] TimeCnt = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e          state_q;
    logic [15:0]     mar_q;
    logic [15:0]     mdr_q;
    logic            we_q;
    logic            err_q;
    logic [CntW-1:0] cnt_q;
    logic            busy_q;
    logic            done_q;
    logic            mioen_q;
    logic            rw_q;
    logic            min_ok;

    // cnt_q counts completed ACCESS cycles, so cnt_q + 1 is the current cycle number.
    assign min_ok = (32'(cnt_q) + 32'd1) >= MIN_WAIT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            mar_q   <= '0;
            mdr_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mioen_q <= 1'b0;
            rw_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req) begin
                        mar_q   <= addr;
                        we_q    <= we;
                        if (we) mdr_q <= wdata;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        mioen_q <= 1'b1;
                        rw_q    <= we;
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    if (R && min_ok) begin
                        if (!we_q) mdr_q <= memRData;
                        mioen_q <= 1'b0;
                        rw_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else if (cnt_q == TimeCnt) begin
                        err_q   <= 1'b1;
                        mioen_q <= 1'b0;
                        rw_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    mioen_q <= 1'b0;
                    rw_q    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = done_q & err_q;
    assign rdata    = mdr_q;
    assign MIOEN    = mioen_q;
    assign RW       = rw_q;
    assign memAddr  = mar_q;
    assign memWData = mdr_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master: one default instance plus one with MIN_WAIT=3,
// both served by a simple combinational memory model.
module tb_mem_bus_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_a = 1'b0;
    logic        req_b = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    logic        R = 1'b1;

    logic        a_busy, a_done, a_err, a_mioen, a_rw;
    logic [15:0] a_rdata, a_memaddr, a_memwdata, a_memrdata;
    logic        b_busy, b_done, b_err, b_mioen, b_rw;
    logic [15:0] b_rdata, b_memaddr, b_memwdata, b_memrdata;

    logic [15:0] mem [0:65535];

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    mem_bus_master dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .we(we), .addr(addr), .wdata(wdata),
        .busy(a_busy), .done(a_done), .err(a_err), .rdata(a_rdata),
        .MIOEN(a_mioen), .RW(a_rw), .memAddr(a_memaddr), .memWData(a_memwdata),
        .memRData(a_memrdata), .R(R)
    );

    mem_bus_master #(.MIN_WAIT(3), .TIMEOUT(15)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .we(we), .addr(addr), .wdata(wdata),
        .busy(b_busy), .done(b_done), .err(b_err), .rdata(b_rdata),
        .MIOEN(b_mioen), .RW(b_rw), .memAddr(b_memaddr), .memWData(b_memwdata),
        .memRData(b_memrdata), .R(R)
    );

    assign a_memrdata = mem[a_memaddr];
    assign b_memrdata = mem[b_memaddr];

    always @(posedge clk) begin
        if (a_mioen && a_rw) mem[a_memaddr] <= a_memwdata;
    end

    logic        sel = 1'b0;
    logic        done_s, err_s, mioen_s, rw_s;
    logic [15:0] rdata_s, addr_s, wdata_s;
    assign done_s  = sel ? b_done : a_done;
    assign err_s   = sel ? b_err : a_err;
    assign mioen_s = sel ? b_mioen : a_mioen;
    assign rw_s    = sel ? b_rw : a_rw;
    assign rdata_s = sel ? b_rdata : a_rdata;
    assign addr_s  = sel ? b_memaddr : a_memaddr;
    assign wdata_s = sel ? b_memwdata : a_memwdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction; R is low for the first rlow ACCESS cycles, then high.
    task automatic txn(input logic s, input logic w, input logic [15:0] a, input logic [15:0] d,
                       input int rlow, output int mio, output logic dn, output logic er,
                       output logic [15:0] rd, output logic rw0, output logic [15:0] ad0,
                       output logic [15:0] wd0);
        sel = s;
        @(negedge clk);
        we = w; addr = a; wdata = d;
        if (s) req_b = 1'b1; else req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0; req_b = 1'b0;
        mio = 0; dn = 1'b0; er = 1'b0; rd = '0; rw0 = 1'b0; ad0 = '0; wd0 = '0;
        for (int i = 0; i < 40; i++) begin
            if (done_s) begin
                dn = 1'b1; er = err_s; rd = rdata_s;
                break;
            end
            if (mioen_s) begin
                if (mio == 0) begin
                    rw0 = rw_s; ad0 = addr_s; wd0 = wdata_s;
                end
                R = (mio >= rlow);
                mio++;
            end
            @(negedge clk);
        end
        R = 1'b1;
    endtask

    int          mio;
    logic        dn, er, rw0;
    logic [15:0] rd, ad0, wd0;
    int          ndone;

    initial begin
        mem[16'h3000] = 16'h5260;
        mem[16'h3100] = 16'h0000;
        mem[16'h3005] = 16'h1234;

        // Reset state
        #12;
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        chk("rst_mioen", 32'(a_mioen), 32'd0);
        chk("rst_rw", 32'(a_rw), 32'd0);
        chk("rst_rdata", 32'(a_rdata), 32'd0);
        chk("rst_memaddr", 32'(a_memaddr), 32'd0);
        chk("rst_memwdata", 32'(a_memwdata), 32'd0);
        rst_n = 1'b1;

        // Default load with R held high
        txn(1'b0, 1'b0, 16'h3000, 16'h0000, 0, mio, dn, er, rd, rw0, ad0, wd0);
        chk("ld_mio_cycles", 32'(mio), 32'd1);
        chk("ld_rw", 32'(rw0), 32'd0);
        chk("ld_addr", 32'(ad0), 32'h3000);
        chk("ld_done", 32'(dn), 32'd1);
        chk("ld_err", 32'(er), 32'd0);
        chk("ld_rdata", 32'(rd), 32'h5260);
        @(negedge clk);
        chk("ld_done_pulse", 32'(a_done), 32'd0);
        chk("ld_idle_busy", 32'(a_busy), 32'd0);

        // Store then load back
        txn(1'b0, 1'b1, 16'h3100, 16'hBEEF, 0, mio, dn, er, rd, rw0, ad0, wd0);
        chk("st_rw", 32'(rw0), 32'd1);
        chk("st_wdata", 32'(wd0), 32'hBEEF);
        chk("st_addr", 32'(ad0), 32'h3100);
        chk("st_done", 32'(dn), 32'd1);
        txn(1'b0, 1'b0, 16'h3100, 16'h0000, 0, mio, dn, er, rd, rw0, ad0, wd0);
        chk("rb_rdata", 32'(rd), 32'hBEEF);
        chk("rb_err", 32'(er), 32'd0);

        // Timeout with R stuck low; MDR keeps the previous read value
        txn(1'b0, 1'b0, 16'h3005, 16'h0000, 99, mio, dn, er, rd, rw0, ad0, wd0);
        chk("to_mio_cycles", 32'(mio), 32'd15);
        chk("to_done", 32'(dn), 32'd1);
        chk("to_err", 32'(er), 32'd1);
        chk("to_rdata", 32'(rd), 32'hBEEF);
        @(negedge clk);
        chk("to_err_clear", 32'(a_err), 32'd0);

        // MIN_WAIT=3 instance
        txn(1'b1, 1'b0, 16'h3000, 16'h0000, 0, mio, dn, er, rd, rw0, ad0, wd0);
        chk("mw3_mio_cycles", 32'(mio), 32'd3);
        chk("mw3_rdata", 32'(rd), 32'h5260);
        txn(1'b1, 1'b0, 16'h3000, 16'h0000, 5, mio, dn, er, rd, rw0, ad0, wd0);
        chk("mw3_rlow_mio_cycles", 32'(mio), 32'd6);
        chk("mw3_rlow_err", 32'(er), 32'd0);
        chk("mw3_rlow_done", 32'(dn), 32'd1);

        // Second req while busy is ignored
        sel = 1'b0;
        @(negedge clk);
        R = 1'b0; we = 1'b0; addr = 16'h3000; req_a = 1'b1;
        @(negedge clk);
        addr = 16'h3001;
        chk("bz_mioen", 32'(a_mioen), 32'd1);
        chk("bz_addr0", 32'(a_memaddr), 32'h3000);
        @(negedge clk);
        chk("bz_busy", 32'(a_busy), 32'd1);
        chk("bz_addr1", 32'(a_memaddr), 32'h3000);
        R = 1'b1;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) chk("bz_rdata", 32'(a_rdata), 32'h5260);
            if (a_done) ndone++;
            req_a = 1'b0;
        end
        chk("bz_done_count", 32'(ndone), 32'd1);
        chk("bz_addr_final", 32'(a_memaddr), 32'h3000);

        // Asynchronous reset in the middle of ACCESS
        @(negedge clk);
        R = 1'b0; we = 1'b0; addr = 16'h3200; req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        chk("ar_mioen_pre", 32'(a_mioen), 32'd1);
        chk("ar_addr_pre", 32'(a_memaddr), 32'h3200);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_mioen", 32'(a_mioen), 32'd0);
        chk("ar_busy", 32'(a_busy), 32'd0);
        chk("ar_memaddr", 32'(a_memaddr), 32'd0);
        #1 rst_n = 1'b1;
        R = 1'b1;
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (a_done) ndone++;
        end
        chk("ar_no_done", 32'(ndone), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
